// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock, fixed 32-cycle latency.
// Shift-add multiply and restoring divide on operand magnitudes, sign fixed up on the final edge.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic              div0_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              finish;
    logic              last;

    assign last = (cnt_q == CW'(ITER - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                // A flush outranks a same-cycle issue: the start is dropped.
                if (kill_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand decode at accept: which operands are signed, and the sign of the final result.
    logic            is_div;
    logic            sgn1, sgn2;
    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        is_div = op_i[2];
        sgn1   = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        sgn2   = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        neg1   = sgn1 & op1_i[XLEN-1];
        neg2   = sgn2 & op2_i[XLEN-1];
        mag1   = neg1 ? -op1_i : op1_i;
        mag2   = neg2 ? -op2_i : op2_i;
    end

    // One iteration of each algorithm; acc holds {hi, lo} for multiply and {rem, quot} for divide.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_tmp;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   res_fix;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_tmp - {1'b0, mcand_q};
        if (op_q[2]) begin
            if (div_diff[XLEN]) acc_next = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else                acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod = neg_q ? -acc_next : acc_next;
        quot = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                    res_fix = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                  res_fix = prod[2*XLEN-1:XLEN];
            // Signed divide by zero would otherwise pick up a quotient sign flip.
            OP_DIV, OP_DIVU:           res_fix = div0_q ? '1 : quot;
            default:                   res_fix = rem;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= op_t'(op_i);
            cnt_q    <= '0;
            neg_q    <= (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
            div0_q   <= (op2_i == '0);
            mcand_q  <= is_div ? mag2 : mag1;
            acc_q    <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
        end else if (state_q == CALC && !kill_i) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 1'b1;
            if (finish) result_q <= res_fix;
        end
    end

    assign busy_o   = (state_q == CALC);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: all RV32M ops, special cases, back-to-back, kill and reset.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .kill_i   (kill_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble the inputs during CALC, then check latency, result and the done pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        @(negedge clk_i);
        op_i = op; op1_i = a; op2_i = b; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; op1_i = ~a; op2_i = b + 32'd1; op_i = op ^ 3'b001;
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        check({tag, " busy_cycles"}, 32'(n), 32'd32);
        check({tag, " done"}, {31'd0, done_o}, 32'd1);
        check({tag, " result"}, result_o, exp);
        @(negedge clk_i);
        check({tag, " done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int  m;
        bit  seen;

        rstn_i = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        op_i = 3'b000; op1_i = '0; op2_i = '0;
        #1;
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;

        // Multiply family
        run_op("mul", 3'b000, 32'h0001_2345, 32'h0000_6789, 32'h75CC_A2ED);
        run_op("mul_neg", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);
        run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        // Divide family
        run_op("div", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("rem", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
        run_op("rem_negdvd", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // Special cases
        run_op("divu_by0", 3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", 3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234);
        run_op("div_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Back-to-back: start held through DONE, extra start pulses during CALC ignored
        @(negedge clk_i);
        op_i = 3'b000; op1_i = 32'd3; op2_i = 32'd5; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        m = 0;
        while (!done_o && m < 40) begin
            m++;
            @(negedge clk_i);
        end
        check("b2b first done", {31'd0, done_o}, 32'd1);
        check("b2b first result", result_o, 32'd15);
        op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; start_i = 1'b1;
        @(negedge clk_i);
        check("b2b no bubble busy", {31'd0, busy_o}, 32'd1);
        check("b2b held result", result_o, 32'd15);
        m = 1;
        while (!done_o && m < 40) begin
            start_i = (m == 3 || m == 20);
            if (m == 3) begin
                op_i = 3'b000; op1_i = 32'd2; op2_i = 32'd2;
            end
            @(negedge clk_i);
            m++;
        end
        start_i = 1'b0;
        check("b2b done spacing", 32'(m), 32'd33);
        check("b2b second result", result_o, 32'd14);
        @(negedge clk_i);
        check("b2b stray start ignored", {31'd0, busy_o}, 32'd0);

        // kill at CALC cycle 10
        @(negedge clk_i);
        op_i = 3'b101; op1_i = 32'd1000; op2_i = 32'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("kill pre busy", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill busy", {31'd0, busy_o}, 32'd0);
        check("kill done", {31'd0, done_o}, 32'd0);
        check("kill result kept", result_o, 32'd14);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen = 1'b1;
        end
        check("kill no done", {31'd0, seen}, 32'd0);

        // kill in DONE wins over a same-cycle start
        @(negedge clk_i);
        op_i = 3'b011; op1_i = 32'hFFFF_FFFF; op2_i = 32'hFFFF_FFFF; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        m = 0;
        while (!done_o && m < 40) begin
            m++;
            @(negedge clk_i);
        end
        check("killdone result", result_o, 32'hFFFF_FFFE);
        kill_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0; start_i = 1'b0;
        check("killdone start dropped", {31'd0, busy_o}, 32'd0);
        check("killdone result kept", result_o, 32'hFFFF_FFFE);

        // Reset at CALC cycle 5
        @(negedge clk_i);
        op_i = 3'b000; op1_i = 32'd9; op2_i = 32'd9; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        check("rst_mid busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid done", {31'd0, done_o}, 32'd0);
        check("rst_mid result", result_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        check("rst_mid no done", {31'd0, seen}, 32'd0);
        run_op("post_reset", 3'b111, 32'd23, 32'd5, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
